// File: rtl/sig_bundle_pkg.sv
// Shared types for the x/y/z signal-bundle delay queue.
// Provides the bundle struct, the queue entry struct and the default timestamp width.
package sig_bundle_pkg;

    localparam int TW_DEFAULT = 6;

    typedef struct packed {
        logic x;
        logic y;
        logic z;
    } sig_bundle_t;

    typedef struct packed {
        sig_bundle_t              b;
        logic [TW_DEFAULT-1:0]    due;
    } dq_entry_t;

endpackage

// File: rtl/sig_bundle_queue_mem.sv
// In-order entry storage for the bundle delay queue.
// Ports: clk/rst, push/pop strobes, write bundle+due, head bundle, read pointer,
//        per-entry valid bits and due times, full flag and occupancy level.
module sig_bundle_queue_mem
    import sig_bundle_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TW = TW_DEFAULT,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  sig_bundle_t                wr_bundle,
    input  logic [TW-1:0]              wr_due,
    output sig_bundle_t                head_bundle,
    output logic [AW-1:0]              rd_ptr,
    output logic [DEPTH-1:0]           valid,
    output logic [DEPTH-1:0][TW-1:0]   dues,
    output logic                       full,
    output logic [LW-1:0]              level
);

    sig_bundle_t   bundles [DEPTH];
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + AW'(1);
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Payload needs no reset: valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            bundles[wr_ptr] <= wr_bundle;
            dues[wr_ptr]    <= wr_due;
        end
    end

    assign head_bundle = bundles[rd_ptr];
    assign full        = (level == LW'(DEPTH));

endmodule

// File: rtl/sig_bundle_delay_queue.sv
// Delay queue releasing x/y/z bundles in order once their per-entry delay expires.
// Ports: clk, rst, in_valid/in_ready/in_bundle/in_delay upstream,
//        out_valid/out_ready/out_bundle downstream, level occupancy.
module sig_bundle_delay_queue
    import sig_bundle_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int MAX_DELAY = 31,
    localparam int DW = $clog2(MAX_DELAY + 1),
    localparam int TW = $clog2(MAX_DELAY + 2),
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  sig_bundle_t     in_bundle,
    input  logic [DW-1:0]   in_delay,
    output logic            out_valid,
    input  logic            out_ready,
    output sig_bundle_t     out_bundle,
    output logic [LW-1:0]   level
);

    logic [TW-1:0]             now;
    logic [TW-1:0]             delay_c;
    logic [TW-1:0]             due;
    logic                      push;
    logic                      pop;
    logic                      full;
    logic                      head_valid;
    logic [AW-1:0]             rd_ptr;
    logic [DEPTH-1:0]          valid;
    logic [DEPTH-1:0][TW-1:0]  dues;
    logic [DEPTH-1:0]          ripe;
    sig_bundle_t               head_bundle;
    sig_bundle_t               held;

    always_ff @(posedge clk) begin
        if (rst) now <= '0;
        else     now <= now + TW'(1);
    end

    assign delay_c = (TW'(in_delay) > TW'(MAX_DELAY)) ? TW'(MAX_DELAY) : TW'(in_delay);
    // The +1 makes the entry ripe no earlier than the cycle it becomes visible.
    assign due     = now + delay_c + TW'(1);

    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    sig_bundle_queue_mem #(
        .DEPTH (DEPTH),
        .TW    (TW)
    ) u_mem (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .wr_bundle   (in_bundle),
        .wr_due      (due),
        .head_bundle (head_bundle),
        .rd_ptr      (rd_ptr),
        .valid       (valid),
        .dues        (dues),
        .full        (full),
        .level       (level)
    );

    // Sticky ripe bits: an equality hit is latched so that counter wrap
    // during long backpressure can never make an entry unripe again.
    always_ff @(posedge clk) begin
        if (rst) begin
            ripe <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pop && i == int'(rd_ptr))
                    ripe[i] <= 1'b0;
                else if (valid[i] && now == dues[i])
                    ripe[i] <= 1'b1;
            end
        end
    end

    assign head_valid = valid[rd_ptr];
    assign out_valid  = head_valid && (ripe[rd_ptr] || now == dues[rd_ptr]);

    always_ff @(posedge clk) begin
        if (rst)      held <= '0;
        else if (pop) held <= head_bundle;
    end

    assign out_bundle = out_valid ? head_bundle : held;

endmodule

// File: doc/sig_bundle_delay_queue.md
Name: sig_bundle_delay_queue

Overview:
- Sits directly downstream of the x/y/z signal-bundle producer.
- Accepts bundles with a per-entry cycle delay and holds each one in an in-order queue.
- Releases each bundle on a valid/ready output once its delay has expired.
- Provides cycle-accurate, synthesizable release timing in place of procedural intra-assignment delays (#N) on bundle fields.

Parameters:
- DEPTH, 4: queue entries; power of two, >= 2.
- MAX_DELAY, 31: largest honoured delay in cycles; larger requests are clamped to this value.
- DW, $clog2(MAX_DELAY+1): localparam, width of in_delay.
- TW, $clog2(MAX_DELAY+2): localparam, width of the timestamp counter and the stored due time.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents a bundle.
- in_ready  out  1  queue can accept; equals !full.
- in_bundle  in  3  sig_bundle_t {x,y,z}; x is the MSB.
- in_delay  in  DW  release delay in cycles for this bundle.
- out_valid  out  1  head bundle is present and ripe.
- out_ready  in  1  downstream accepts.
- out_bundle  out  3  head bundle; holds its last popped value when out_valid=0.
- level  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all valid bits cleared, rd/wr pointers = 0, now = 0, level = 0, out_valid = 0, out_bundle = 3'b000, in_ready = 1.
- Reset mid-operation: every stored entry is discarded with no release, and the counter restarts at 0.
- Counter: now is a free-running TW-bit counter that increments every cycle and wraps modulo 2^TW.
- Push: happens when in_valid && in_ready in cycle t.
  - The entry stores the bundle and due = now + min(in_delay, MAX_DELAY) + 1, computed modulo 2^TW.
  - The entry becomes visible from cycle t+1.
- Ripe tracking:
  - Each entry has a sticky ripe bit, set in any cycle where the entry is valid and now == due.
  - The ripe bit clears on pop.
  - An equality compare is used, never magnitude, so wrap-around and arbitrarily long backpressure cannot un-ripen an entry.
- Release:
  - out_valid = head valid && (ripe[head] || now == due[head]), i.e. combinational on the same-cycle match.
  - Latency: with no backpressure and no head-of-line blocking, a bundle pushed in cycle t with delay d has out_valid high in cycle t+1+d.
  - d = 0 gives out_valid in cycle t+1. There is no same-cycle bypass.
- Pop: happens when out_valid && out_ready. The head entry is freed and out_bundle then shows the next head.
- Ordering: strictly FIFO. A later entry with a shorter delay waits behind an unripe head; its ripe bit still sets on time, so it is released in the cycle after the head pops.
- Backpressure: if out_ready stays low, the head is held with out_valid stable high and out_bundle stable.
- Full: in_ready = 0 whenever level == DEPTH, even if a pop occurs in that cycle. There is no push-through when full.
- Simultaneous push and pop when not full: both take effect and level is unchanged.
- Empty: out_valid = 0.
- Protocol violation: in_valid while in_ready = 0 is ignored and the bundle is dropped. The assertion in_ready || !in_valid belongs in the bench, not the RTL.

Decomposition:
- Package sig_bundle_pkg:
  - typedef struct packed {logic x; logic y; logic z;} sig_bundle_t.
  - typedef struct packed {sig_bundle_t b; logic [TW-1:0] due;} dq_entry_t, parameterised through a localparam default TW_DEFAULT = 6.
- One sub-module, sig_bundle_queue_mem: a DEPTH-entry register array with pointers, valid bits and level.
- Top level holds the counter, the due-time computation, the per-entry ripe logic and the handshake.

Test Plan:
1. Release timing: reset, then push {x=1,y=0,z=1} with delay 10 in cycle 5, out_ready=1 -> out_valid rises in cycle 16 with out_bundle=3'b101, high for exactly 1 cycle; level goes 0 -> 1 -> 0.
2. Zero delay and clamping: push with delay 0 in cycle t -> out_valid in t+1. Push with in_delay=31 (MAX_DELAY) -> out_valid at t+32.
3. Head-of-line blocking: push A (delay 8), then B (delay 1) the next cycle -> A released at t+9, B at t+10, in order.
4. Full: push 4 entries, delay 20 -> in_ready=0 and level=4. A 5th in_valid is ignored. After the first pop, in_ready returns to 1 in the following cycle.
5. Backpressure across counter wrap: push delay 3, hold out_ready=0 for 200 cycles -> out_valid stays high and out_bundle stable throughout; pop on the first cycle out_ready=1.
6. Reset mid-operation: 3 entries queued, assert rst for 1 cycle -> next cycle level=0, out_valid=0, in_ready=1, and no stale bundle is ever released afterwards.
